// File: rtl/baccarat_pkg.sv
// baccarat_pkg
//   Shared definitions for the card datapath: card codes, deal FSM states,
//   hand-slot indices and the baccarat card-value / score helpers.
//   Used by the hand deal unit, the display decoders and the control FSM.
package baccarat_pkg;

  localparam int DEF_CARD_W    = 4;
  localparam int DEF_NUM_RANKS = 13;
  localparam int NUM_SLOTS     = 6;

  typedef enum logic [3:0] {
    BLANK = 4'd0,
    ACE   = 4'd1,
    TWO   = 4'd2,
    THREE = 4'd3,
    FOUR  = 4'd4,
    FIVE  = 4'd5,
    SIX   = 4'd6,
    SEVEN = 4'd7,
    EIGHT = 4'd8,
    NINE  = 4'd9,
    TEN   = 4'd10,
    JACK  = 4'd11,
    QUEEN = 4'd12,
    KING  = 4'd13
  } card_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    ACK  = 2'd2
  } deal_state_t;

  localparam logic [2:0] SLOT_P1 = 3'd0;
  localparam logic [2:0] SLOT_P2 = 3'd1;
  localparam logic [2:0] SLOT_P3 = 3'd2;
  localparam logic [2:0] SLOT_D1 = 3'd3;
  localparam logic [2:0] SLOT_D2 = 3'd4;
  localparam logic [2:0] SLOT_D3 = 3'd5;

  // Ace..nine count face value; blank, ten and court cards count zero.
  function automatic logic [3:0] card_value(input card_t c);
    logic [3:0] code;
    code = c;
    if (code >= 4'd1 && code <= 4'd9) begin
      return code;
    end
    return 4'd0;
  endfunction

  // Three card values sum to at most 27, so two conditional subtractions
  // are enough to reduce modulo 10.
  function automatic logic [3:0] score_mod10(input logic [4:0] sum);
    logic [4:0] r;
    if (sum >= 5'd20) begin
      r = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      r = sum - 5'd10;
    end else begin
      r = sum;
    end
    return r[3:0];
  endfunction

endpackage

// File: rtl/rank_counter.sv
// rank_counter
//   Free-running card rank source. Counts 1..NUM_RANKS and wraps back to 1;
//   it never shows 0. Kept separate so a pseudo-random source can later be
//   dropped in with the same ports.
// Ports
//   clk    in   system clock
//   reset  in   synchronous active-high reset, counter restarts at 1
//   rank   out  current rank code
module rank_counter #(
  parameter int NUM_RANKS = 13,
  parameter int CARD_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [CARD_W-1:0] rank
);

  logic [CARD_W-1:0] rank_q;
  logic [CARD_W-1:0] rank_d;

  always_comb begin
    rank_d = rank_q + CARD_W'(1);
    if (rank_q == CARD_W'(NUM_RANKS)) begin
      rank_d = CARD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rank_q <= CARD_W'(1);
    end else begin
      rank_q <= rank_d;
    end
  end

  assign rank = rank_q;

endmodule

// File: rtl/hand_deal_unit.sv
// hand_deal_unit
//   Deals card ranks into six hand slots (player P1..P3, dealer D1..D3) on
//   one-card requests over a four-phase req/ack handshake, and presents the
//   slot codes and both baccarat hand scores.
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   clear_hands  in   blank all slots and abort any deal in progress
//   deal_req     in   request one card, held until deal_ack
//   deal_slot    in   target slot 0..5 (P1..P3, D1..D3); 6,7 illegal
//   deal_ack     out  request complete, held until deal_req falls
//   deal_err     out  valid with deal_ack: request refused, nothing written
//   busy         out  FSM not idle
//   pcard1..3    out  player slot codes
//   dcard1..3    out  dealer slot codes
//   pscore       out  player hand score 0..9
//   dscore       out  dealer hand score 0..9
module hand_deal_unit
  import baccarat_pkg::*;
#(
  parameter int NUM_RANKS = DEF_NUM_RANKS,
  parameter int CARD_W    = DEF_CARD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_hands,
  input  logic              deal_req,
  input  logic [2:0]        deal_slot,
  output logic              deal_ack,
  output logic              deal_err,
  output logic              busy,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [3:0]        pscore,
  output logic [3:0]        dscore
);

  deal_state_t       state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              clr_slots;
  logic [CARD_W-1:0] rank;

  logic [CARD_W-1:0] slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [NUM_SLOTS-1:0] slot_full;
  logic [3:0]        slot_val [NUM_SLOTS];

  logic              sel_illegal;
  logic              target_full;

  rank_counter #(
    .NUM_RANKS (NUM_RANKS),
    .CARD_W    (CARD_W)
  ) u_rank (
    .clk   (clk),
    .reset (reset),
    .rank  (rank)
  );

  // Slot register file: one register per slot with a decoded write strobe.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign slot_hit[gi]  = (sel_q == 3'(gi));
    assign slot_full[gi] = (slot_q[gi] != '0);
    assign slot_val[gi]  = card_value(card_t'(slot_q[gi]));

    always_ff @(posedge clk) begin
      if (reset || clr_slots) begin
        slot_q[gi] <= '0;
      end else if (wr_en && slot_hit[gi]) begin
        slot_q[gi] <= rank;
      end
    end
  end

  assign sel_illegal = (sel_q > SLOT_D3);
  assign target_full = |(slot_hit & slot_full);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ack_d     = ack_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    clr_slots = 1'b0;

    if (clear_hands) begin
      // Overrides any deal in flight, including the DRAW write.
      state_d   = IDLE;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      clr_slots = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ack_d = 1'b0;
          err_d = 1'b0;
          if (deal_req) begin
            state_d = DRAW;
            sel_d   = deal_slot;
          end
        end
        DRAW: begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (sel_illegal || target_full) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            wr_en = 1'b1;
          end
        end
        ACK: begin
          if (!deal_req) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign deal_ack = ack_q;
  assign deal_err = err_q;
  assign busy     = (state_q != IDLE);

  assign pcard1 = slot_q[SLOT_P1];
  assign pcard2 = slot_q[SLOT_P2];
  assign pcard3 = slot_q[SLOT_P3];
  assign dcard1 = slot_q[SLOT_D1];
  assign dcard2 = slot_q[SLOT_D2];
  assign dcard3 = slot_q[SLOT_D3];

  logic [4:0] psum, dsum;

  assign psum = {1'b0, slot_val[SLOT_P1]} + {1'b0, slot_val[SLOT_P2]}
              + {1'b0, slot_val[SLOT_P3]};
  assign dsum = {1'b0, slot_val[SLOT_D1]} + {1'b0, slot_val[SLOT_D2]}
              + {1'b0, slot_val[SLOT_D3]};

  assign pscore = score_mod10(psum);
  assign dscore = score_mod10(dsum);

endmodule

// File: tb/tb_hand_deal_unit.sv
// tb_hand_deal_unit
//   Directed and randomized deals checked against a behavioural model of the
//   hand: rank is derived from the cycle count since reset, slots are a plain
//   array, scores are the sum of card values modulo 10.
module tb_hand_deal_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_hands = 1'b0;
  logic       deal_req = 1'b0;
  logic [2:0] deal_slot = 3'd0;
  logic       deal_ack, deal_err, busy;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;

  int n_cmp  = 0;
  int n_fail = 0;
  int cnt    = 0;   // rising edges since the last reset edge
  int m_slot [6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else       cnt <= cnt + 1;
  end

  hand_deal_unit dut (
    .clk         (clk),
    .reset       (reset),
    .clear_hands (clear_hands),
    .deal_req    (deal_req),
    .deal_slot   (deal_slot),
    .deal_ack    (deal_ack),
    .deal_err    (deal_err),
    .busy        (busy),
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pscore      (pscore),
    .dscore      (dscore)
  );

  // Rank the counter will hold during the next cycle (one edge ahead).
  function automatic int next_rank();
    return ((cnt + 1) % 13) + 1;
  endfunction

  function automatic int value_of(input int code);
    return (code >= 1 && code <= 9) ? code : 0;
  endfunction

  function automatic int model_score(input int base);
    return (value_of(m_slot[base]) + value_of(m_slot[base+1])
            + value_of(m_slot[base+2])) % 10;
  endfunction

  function automatic int dut_slot(input int i);
    case (i)
      0: return int'(pcard1);
      1: return int'(pcard2);
      2: return int'(pcard3);
      3: return int'(dcard1);
      4: return int'(dcard2);
      default: return int'(dcard3);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hand(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s.slot%0d", tag, i), dut_slot(i), m_slot[i]);
    end
    chk({tag, ".pscore"}, int'(pscore), model_score(0));
    chk({tag, ".dscore"}, int'(dscore), model_score(3));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) m_slot[i] = 0;
  endtask

  // Full handshake; entered and left at a falling edge with deal_req low
  // (or already high, which behaves the same from IDLE).
  task automatic deal(input int s, input int hold, input string tag);
    int  rk;
    bit  exp_err;
    rk = next_rank();
    deal_req  = 1'b1;
    deal_slot = 3'(s);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".busy_draw"}, int'(busy), 1);
    chk({tag, ".noack_draw"}, int'(deal_ack), 0);
    deal_slot = 3'($urandom_range(7, 0));  // must be ignored after capture
    @(posedge clk);
    @(negedge clk);
    exp_err = (s > 5) || (m_slot[s] != 0);
    if (!exp_err) m_slot[s] = rk;
    chk({tag, ".ack"}, int'(deal_ack), 1);
    chk({tag, ".err"}, int'(deal_err), int'(exp_err));
    chk_hand(tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".ack_held"}, int'(deal_ack), 1);
      chk({tag, ".err_held"}, int'(deal_err), int'(exp_err));
      chk_hand({tag, ".held"});
    end
    deal_req = 1'b0;
    @(negedge clk);
    chk({tag, ".ack_drop"}, int'(deal_ack), 0);
    chk({tag, ".err_drop"}, int'(deal_err), 0);
    chk({tag, ".idle"}, int'(busy), 0);
    $display("deal slot=%0d rank=%0d err=%0d hold=%0d P=%0d D=%0d", s, rk,
             exp_err, hold, model_score(0), model_score(3));
  endtask

  task automatic wait_for_rank(input int target);
    for (int i = 0; i < 14 && next_rank() != target; i++) @(negedge clk);
    chk("wait_rank", next_rank(), target);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst.ack", int'(deal_ack), 0);
    chk("rst.err", int'(deal_err), 0);
    chk("rst.busy", int'(busy), 0);
    chk_hand("rst");

    // 1: request in the first cycle after reset draws rank 2 into P1
    reset = 1'b0;
    chk("t1.first_rank", next_rank(), 2);
    deal(0, 0, "t1");

    // 2: draw 7, 13, 8 into P1..P3 after a clear
    clear_hands = 1'b1;
    @(negedge clk);
    clear_hands = 1'b0;
    model_clear();
    chk_hand("t2.clr");
    wait_for_rank(7);
    deal(0, 0, "t2a");
    wait_for_rank(13);
    deal(1, 1, "t2b");
    wait_for_rank(8);
    deal(2, 0, "t2c");
    chk("t2.pscore5", int'(pscore), 5);
    repeat (13) @(negedge clk);   // full wrap of the rank sequence
    deal(3, 0, "t2wrap");

    // 3: illegal slot, request held five cycles
    deal(6, 5, "t3");
    deal(7, 0, "t3b");

    // 4: second deal into filled D1 is refused
    deal(3, 2, "t4");

    // 5: clear during DRAW aborts the deal
    deal_req  = 1'b1;
    deal_slot = 3'd4;
    @(posedge clk);
    @(negedge clk);
    clear_hands = 1'b1;
    deal_req    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear_hands = 1'b0;
    model_clear();
    chk("t5.ack", int'(deal_ack), 0);
    chk("t5.busy", int'(busy), 0);
    chk_hand("t5");
    @(negedge clk);
    chk("t5.still_idle", int'(busy), 0);

    // 5b: request held through a clear restarts from IDLE
    deal(1, 0, "t5b_fill");
    deal_req  = 1'b1;
    deal_slot = 3'd1;
    @(posedge clk);
    @(negedge clk);
    clear_hands = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_hands = 1'b0;
    model_clear();
    chk("t5b.ack", int'(deal_ack), 0);
    chk_hand("t5b.clr");
    deal(1, 0, "t5b");

    // 6: reset in ACK with request still high
    deal_req  = 1'b1;
    deal_slot = 3'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6.ack_pre", int'(deal_ack), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    chk("t6.ack", int'(deal_ack), 0);
    chk("t6.err", int'(deal_err), 0);
    chk("t6.busy", int'(busy), 0);
    chk_hand("t6");
    reset = 1'b0;
    chk("t6.rank_restart", next_rank(), 2);
    deal(5, 0, "t6b");

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(4, 0);
      repeat (gap) @(negedge clk);
      if ($urandom_range(9, 0) == 0) begin
        clear_hands = 1'b1;
        @(negedge clk);
        clear_hands = 1'b0;
        model_clear();
        chk_hand("rnd.clr");
      end
      deal($urandom_range(7, 0), $urandom_range(3, 0),
           $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
